c_credit_sched: RTL and testbench



---
 rtl/c_credit_sched.sv | 142 ++++++++++++++
 tb/tb_c_credit_sched.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/c_credit_sched.sv
// Round-robin scheduler sharing one downstream FIFO across num_ports requesters via credits.
// Define C_CREDIT_SCHED_BYPASS_EN to let a credit returned at free=0 be granted in the same cycle.
`ifndef RESET_TYPE_SYNC
`define RESET_TYPE_SYNC 1
`endif

module c_dff #(
    parameter int               width       = 1,
    parameter logic [width-1:0] reset_value = '0,
    parameter int               reset_type  = `RESET_TYPE_SYNC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    generate
        if (reset_type == `RESET_TYPE_SYNC) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset)       q <= reset_value;
                else if (active) q <= d;
            end
        end else begin : g_async
            always_ff @(posedge clk or posedge reset) begin
                if (reset)       q <= reset_value;
                else if (active) q <= d;
            end
        end
    endgenerate
endmodule

module c_credit_sched #(
    parameter int num_ports  = 4,
    parameter int depth      = 8,
    parameter int reset_type = `RESET_TYPE_SYNC
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           active,
    input  logic [0:num_ports-1]           req,
    input  logic [0:num_ports-1]           tail,
    input  logic                           cred_ret,
    output logic [0:num_ports-1]           gnt,
    output logic [0:$clog2(depth+1)-1]     free,
    output logic                           empty,
    output logic                           full,
    output logic                           locked,
    output logic [0:1]                     errors
);
    localparam int               pw      = $clog2(num_ports);
    localparam int               cw      = $clog2(depth+1);
    localparam logic [cw-1:0]    depth_c = cw'(depth);

    typedef enum logic {st_idle, st_locked} state_t;

    state_t         state_q;
    logic [pw-1:0]  ptr_q, owner_q, winner, cand;
    logic           found, credit_avail, gnt_any, locked_q;
    logic [cw-1:0]  free_q, free_s;
    logic           empty_q, full_q;

`ifdef C_CREDIT_SCHED_BYPASS_EN
    assign credit_avail = (free_q != '0) | cred_ret;
`else
    assign credit_avail = (free_q != '0);
`endif

    // Scan downward so the requester closest to the pointer is the last assignment.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = num_ports-1; i >= 0; i--) begin
            cand = pw'((int'(ptr_q) + i) % num_ports);
            if (req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (active && !reset && credit_avail) begin
            if (state_q == st_locked) gnt[owner_q] = req[owner_q];
            else if (found)           gnt[winner]  = 1'b1;
        end
    end

    assign gnt_any = |gnt;

    // Return with no grant at full credit saturates rather than wrapping.
    always_comb begin
        free_s = free_q;
        if (gnt_any && !cred_ret)
            free_s = free_q - 1'b1;
        else if (cred_ret && !gnt_any && free_q != depth_c)
            free_s = free_q + 1'b1;
    end

    c_dff #(.width(cw), .reset_value(depth_c), .reset_type(reset_type)) u_free (
        .clk(clk), .reset(reset), .active(active), .d(free_s), .q(free_q));
    c_dff #(.width(1), .reset_value(1'b1), .reset_type(reset_type)) u_empty (
        .clk(clk), .reset(reset), .active(active), .d(free_s == depth_c), .q(empty_q));
    c_dff #(.width(1), .reset_value(1'b0), .reset_type(reset_type)) u_full (
        .clk(clk), .reset(reset), .active(active), .d(free_s == '0), .q(full_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= st_idle;
            ptr_q    <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
        end else if (active) begin
            case (state_q)
                st_idle: if (gnt_any) begin
                    ptr_q <= (winner == pw'(num_ports-1)) ? '0 : winner + 1'b1;
                    if (!tail[winner]) begin
                        owner_q  <= winner;
                        state_q  <= st_locked;
                        locked_q <= 1'b1;
                    end
                end
                st_locked: if (gnt_any && tail[owner_q]) begin
                    state_q  <= st_idle;
                    locked_q <= 1'b0;
                end
                default: begin
                    state_q  <= st_idle;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign free   = free_q;
    assign empty  = empty_q;
    assign full   = full_q;
    assign locked = locked_q;
    assign errors = {cred_ret & empty_q & ~gnt_any, |(tail & ~req)};
endmodule

// File: tb/tb_c_credit_sched.sv
// Directed + random bench for c_credit_sched against a cycle-level arithmetic model.
module tb_c_credit_sched;
    localparam int N = 4;
    localparam int D = 8;

    logic           clk, reset, active, cred_ret;
    logic [0:N-1]   req, tail, gnt;
    logic [0:3]     free;
    logic           empty, full, locked;
    logic [0:1]     errors;

    int total = 0;
    int bad   = 0;

    int m_free  = D;
    int m_ptr   = 0;
    int m_owner = 0;
    bit m_locked = 0;

    c_credit_sched #(.num_ports(N), .depth(D)) dut (
        .clk(clk), .reset(reset), .active(active), .req(req), .tail(tail),
        .cred_ret(cred_ret), .gnt(gnt), .free(free), .empty(empty), .full(full),
        .locked(locked), .errors(errors));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check combinational outputs, clock, advance the model, check registers.
    task automatic step(input logic [0:N-1] r, input logic [0:N-1] t, input logic c,
                        input logic a, input logic rs);
        logic [0:N-1] eg;
        logic [0:1]   ee;
        int           w;
        bit           credit;
        @(negedge clk);
        req = r; tail = t; cred_ret = c; active = a; reset = rs;
        #1;
        eg = '0;
        w  = -1;
        credit = (m_free != 0);
`ifdef C_CREDIT_SCHED_BYPASS_EN
        credit = credit || c;
`endif
        if (!rs && a && credit) begin
            if (m_locked) begin
                if (r[m_owner]) w = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (r[(m_ptr + k) % N]) begin
                        w = (m_ptr + k) % N;
                        break;
                    end
                end
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        ee = {c && (m_free == D) && (w < 0), |(t & ~r)};
        chk("gnt", gnt, eg);
        chk("errors", errors, ee);
        @(posedge clk);
        #1;
        if (rs) begin
            m_free = D; m_ptr = 0; m_owner = 0; m_locked = 0;
        end else if (a) begin
            m_free = m_free - (w >= 0 ? 1 : 0) + (c ? 1 : 0);
            if (m_free > D) m_free = D;
            if (w >= 0) begin
                if (!m_locked) begin
                    m_ptr = (w + 1) % N;
                    if (!t[w]) begin m_locked = 1; m_owner = w; end
                end else if (t[w]) begin
                    m_locked = 0;
                end
            end
        end
        chk("free", free, m_free);
        chk("empty", empty, m_free == D);
        chk("full", full, m_free == 0);
        chk("locked", locked, m_locked);
    endtask

    initial begin
        reset = 1'b1; active = 1'b1; cred_ret = 1'b0; req = '0; tail = '0;
        step(4'b0000, 4'b0000, 0, 1, 1);
        step(4'b0000, 4'b0000, 0, 1, 1);

        // Round robin draining all credits, then stall.
        for (int i = 0; i < 8; i++) step(4'b1111, 4'b1111, 0, 1, 0);
        chk("full_after_8", full, 1);
        chk("free_after_8", free, 0);
        step(4'b1111, 4'b1111, 0, 1, 0);
        chk("stall_gnt", gnt, 0);

        // Credit return at free=0.
        step(4'b1111, 4'b1111, 1, 1, 0);
        step(4'b1111, 4'b1111, 0, 1, 0);

        // Three-flit packet from port 2 locks out the others.
        step(4'b0000, 4'b0000, 0, 1, 1);
        step(4'b0010, 4'b0000, 0, 1, 0);
        chk("lock_set", locked, 1);
        step(4'b1111, 4'b0000, 0, 1, 0);
        step(4'b1111, 4'b0010, 0, 1, 0);
        chk("lock_clear", locked, 0);
        step(4'b1101, 4'b1111, 0, 1, 0);

        // Simultaneous grant and return at free=3.
        step(4'b0000, 4'b0000, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(4'b1111, 4'b1111, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(4'b1111, 4'b1111, 1, 1, 0);
        chk("free_hold3", free, 3);

        // Overflow at full credit.
        step(4'b0000, 4'b0000, 1, 1, 1);
        step(4'b0000, 4'b0000, 1, 1, 0);
        chk("ovf_free", free, 8);

        // Inactive cycles hold state and suppress grants.
        step(4'b1111, 4'b0000, 0, 0, 0);
        step(4'b1111, 4'b1111, 1, 0, 0);

        // Reset mid-packet.
        step(4'b0000, 4'b0000, 0, 1, 1);
        step(4'b0010, 4'b0000, 0, 1, 0);
        step(4'b0010, 4'b0000, 0, 1, 0);
        step(4'b1111, 4'b0000, 0, 1, 1);
        chk("rst_locked", locked, 0);
        step(4'b0100, 4'b0000, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [0:N-1] r, t;
            r = N'($urandom);
            t = ($urandom_range(0, 7) == 0) ? N'($urandom) : (N'($urandom) & r);
            step(r, t, $urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
